// File: rtl/ext_dbg_mem_acc.sv
// Debug memory-access engine: turns external-debug scan-chain updates into
// single-byte reads/writes on the AVR data space via a request/grant handshake.
module ext_dbg_mem_acc #(
    parameter int unsigned GNT_TMO = 255,
    parameter int unsigned ADR_W   = 16
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic [18:0]      chain_ac_o,
    input  logic [8:0]       chain_d_o,
    input  logic             chain_ac_ud,
    input  logic             chain_d_ud,
    output logic [18:0]      chain_ac_i,
    output logic [8:0]       chain_d_i,
    output logic             dbg_req,
    input  logic             dbg_gnt,
    output logic [ADR_W-1:0] dbg_adr,
    output logic             dbg_re,
    output logic             dbg_we,
    output logic [7:0]       dbg_dout,
    input  logic [7:0]       dbg_din
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACC,
        ST_RD,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       ac_sync_q, d_sync_q;
    logic [ADR_W-1:0] addr_q, addr_d;
    logic             rnw_q, rnw_d;
    logic             ainc_q, ainc_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             req_q, req_d;
    logic             re_q, re_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [7:0]       dout_q, dout_d;
    logic             ac_start, d_start, op_start;
    logic             unused_bits;

    // Bits of the chain words that carry no meaning for this engine
    assign unused_bits = chain_ac_o[18] ^ chain_d_o[8];

    // Three-flop synchronizers for the TCK-domain update strobes
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            ac_sync_q <= 3'b000;
            d_sync_q  <= 3'b000;
        end else begin
            ac_sync_q <= {ac_sync_q[1:0], chain_ac_ud};
            d_sync_q  <= {d_sync_q[1:0], chain_d_ud};
        end
    end

    assign ac_start = ac_sync_q[1] & ~ac_sync_q[2];
    assign d_start  = d_sync_q[1] & ~d_sync_q[2];

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rnw_d    = rnw_q;
        ainc_d   = ainc_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = done_q;
        err_d    = err_q;
        ovr_d    = ovr_q;
        tmo_d    = tmo_q;
        op_start = 1'b0;
        req_d    = 1'b0;
        re_d     = 1'b0;
        we_d     = 1'b0;
        adr_d    = '0;
        dout_d   = 8'h00;

        case (state_q)
            ST_IDLE: begin
                tmo_d = 8'h00;
                if (ac_start) begin
                    addr_d = chain_ac_o[ADR_W-1:0];
                    rnw_d  = chain_ac_o[16];
                    ainc_d = chain_ac_o[17];
                end
                if (d_start) begin
                    wdata_d = chain_d_o[7:0];
                end
                // A data update alone launches a write only if the latched mode is write
                op_start = ac_start ? (chain_ac_o[16] | d_start) : (d_start & ~rnw_q);
                if (op_start) begin
                    state_d = ST_REQ;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    ovr_d   = 1'b0;
                end
            end
            ST_REQ: begin
                if (dbg_gnt) begin
                    state_d = ST_ACC;
                end else if (tmo_q == 8'(GNT_TMO)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_ACC: begin
                state_d = rnw_q ? ST_RD : ST_DONE;
            end
            ST_RD: begin
                rdata_d = dbg_din;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d = 1'b1;
                if (ainc_q) begin
                    addr_d = addr_q + ADR_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Commands arriving while an operation is in flight are dropped and flagged
        if ((state_q != ST_IDLE) && (ac_start || d_start)) begin
            ovr_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
        req_d  = (state_d == ST_REQ) || (state_d == ST_ACC) || (state_d == ST_RD);
        if (state_d == ST_ACC) begin
            adr_d  = addr_d;
            re_d   = rnw_d;
            we_d   = ~rnw_d;
            dout_d = rnw_d ? 8'h00 : wdata_d;
        end
    end

    // State, datapath and output registers; reset drops the bus strobes at once
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            ainc_q  <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 8'h00;
            req_q   <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            ainc_q  <= ainc_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
            re_q    <= re_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dout_q  <= dout_d;
        end
    end

    assign chain_ac_i = {ovr_q, err_q, busy_q, addr_q};
    assign chain_d_i  = {done_q, rdata_q};
    assign dbg_req    = req_q;
    assign dbg_re     = re_q;
    assign dbg_we     = we_q;
    assign dbg_adr    = adr_q;
    assign dbg_dout   = dout_q;

endmodule
